// File: rtl/uart_word_assembler.sv
// Packs NBYTES consecutive uart_rx bytes into one word, first byte in the MSBs.
// The word is offered on a valid/ready handshake. A stalled partial word is dropped after TIMEOUT_TICKS baud ticks.
module uart_word_assembler #(
    parameter int DBIT          = 8,
    parameter int NBYTES        = 4,
    parameter int TIMEOUT_TICKS = 4096,
    localparam int W            = NBYTES * DBIT,
    localparam int CW           = $clog2(NBYTES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s_tick,
    input  logic          rx_done_tick,
    input  logic [DBIT-1:0] rx_in,
    output logic [W-1:0]  word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [CW-1:0] byte_cnt,
    output logic          overrun,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    localparam int              TW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(NBYTES - 1);
    localparam logic [TW-1:0]   LAST_TICK = TW'(TIMEOUT_TICKS - 1);
    localparam bit              SINGLE    = (NBYTES == 1);

    // Handshake: a word transfers on any cycle where word_valid and word_ready are both high.
    // word_valid is held high until that happens, and word_out does not change while it is high.
    // word_ready has no effect while word_valid is low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_sr;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_valid;
    logic            r_overrun;
    logic            r_timeout;

    logic [W-1:0]    w_shifted;
    logic            w_handshake;

    generate
        if (NBYTES == 1) begin : g_single
            assign w_shifted = rx_in;
        end else begin : g_multi
            assign w_shifted = {r_sr[W-DBIT-1:0], rx_in};
        end
    endgenerate

    assign w_handshake = r_valid & word_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_done_tick) begin
                        r_sr    <= w_shifted;
                        r_cnt   <= CW'(1);
                        r_tcnt  <= '0;
                        r_valid <= SINGLE;
                        r_state <= SINGLE ? S_HOLD : S_FILL;
                    end
                end
                S_FILL: begin
                    // A byte in the same cycle as a tick wins; the tick is not counted.
                    if (rx_done_tick) begin
                        r_sr   <= w_shifted;
                        r_cnt  <= r_cnt + CW'(1);
                        r_tcnt <= '0;
                        if (r_cnt == LAST_CNT) begin
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end else if (s_tick) begin
                        if (r_tcnt == LAST_TICK) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_sr      <= '0;
                            r_tcnt    <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        // A byte arriving on the handshake cycle starts the next word.
                        if (rx_done_tick) begin
                            r_sr    <= w_shifted;
                            r_cnt   <= CW'(1);
                            r_tcnt  <= '0;
                            r_valid <= SINGLE;
                            r_state <= SINGLE ? S_HOLD : S_FILL;
                        end else begin
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                            r_tcnt  <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (rx_done_tick) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end

    assign word_out    = r_sr;
    assign word_valid  = r_valid;
    assign byte_cnt    = r_cnt;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;
    assign dbg_state   = r_state;

endmodule
